zap_reglist_sequencer: RTL and testbench

//  Parametrised LDM/STM register-list sequencer for the predecode stage. Accepts a

---
 rtl/zap_reglist_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_zap_reglist_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_reglist_sequencer.sv
// ---------------------------------------------------------------------------
// zap_reglist_sequencer
//
// Sequences an LDM/STM register list for the predecode stage.
// For each accepted list it emits one beat per set bit. Beats come out in
// ascending register order. Each beat carries the register index and its
// signed byte offset from the base. The base writeback offset is available
// from the cycle after accept.
//
// Optional feature macro: ZAP_REGLIST_PC_FLAG_EN
//   When the macro is defined, the o_pc_hit output is added. It flags a beat
//   that targets the top register (the PC).
//
// Ports
//   i_clk        clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_valid      request valid
//   o_ready      request accepted when i_valid & o_ready (IDLE only)
//   i_list       register list, bit r = register r
//   i_mode       00 IA, 01 IB, 10 DA, 11 DB
//   i_abort      synchronous flush, overrides everything else
//   o_valid      beat valid
//   i_ready      downstream accepts beat
//   o_idx        register index of current beat
//   o_offset     signed byte offset of current beat from base
//   o_first      current beat is first of list
//   o_last       current beat is last of list
//   o_wb_offset  signed base writeback offset, held until the next accept
//   o_done       one-cycle pulse when the list is finished
//   o_pc_hit     (ZAP_REGLIST_PC_FLAG_EN only) beat targets register LIST_W-1
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for a request, o_ready high
// RUN   | emitting beats, o_valid high
// DONE  | list finished, o_done pulse
// ---------------------------------------------------------------------------
module zap_reglist_sequencer #(
    parameter int LIST_W     = 16,
    parameter int IDX_W      = 4,
    parameter int OFF_W      = 12,
    parameter int WORD_BYTES = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [LIST_W-1:0] i_list,
    input  logic [1:0]        i_mode,
    input  logic              i_abort,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [IDX_W-1:0]  o_idx,
    output logic [OFF_W-1:0]  o_offset,
    output logic              o_first,
    output logic              o_last,
    output logic [OFF_W-1:0]  o_wb_offset,
    output logic              o_done
`ifdef ZAP_REGLIST_PC_FLAG_EN
    ,
    output logic              o_pc_hit
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [LIST_W-1:0]   r_mask;
    logic [1:0]          r_mode;
    logic [IDX_W:0]      r_n;
    logic [IDX_W:0]      r_k;
    logic [OFF_W-1:0]    r_wb_offset;

    logic                w_accept;
    logic                w_beat;
    logic [LIST_W-1:0]   w_mask_rest;
    logic                w_last;
    logic [IDX_W-1:0]    w_low_idx;
    logic [IDX_W:0]      w_list_cnt;
    logic [OFF_W-1:0]    w_list_bytes;
    logic [OFF_W-1:0]    w_wb_nxt;
    logic [OFF_W-1:0]    w_k_bytes;
    logic [OFF_W-1:0]    w_n_bytes;
    logic [OFF_W-1:0]    w_word;
    logic [OFF_W-1:0]    w_offset;

    function automatic logic [IDX_W:0] popcount(input logic [LIST_W-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < LIST_W; i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign w_accept = (r_state == ST_IDLE) & i_valid & ~i_abort;
    assign w_beat   = (r_state == ST_RUN) & i_ready & ~i_abort;

    // Clearing the lowest set bit leaves the remaining list. When the
    // remainder is empty, the current beat is the last one.
    assign w_mask_rest = r_mask & (r_mask - LIST_W'(1));
    assign w_last      = (w_mask_rest == '0);

    always_comb begin
        w_low_idx = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    assign w_list_cnt   = popcount(i_list);
    assign w_word       = OFF_W'(WORD_BYTES);
    assign w_list_bytes = OFF_W'(w_list_cnt) * w_word;
    assign w_wb_nxt     = i_mode[1] ? (OFF_W'(0) - w_list_bytes) : w_list_bytes;

    assign w_k_bytes = OFF_W'(r_k) * w_word;
    assign w_n_bytes = OFF_W'(r_n) * w_word;

    always_comb begin
        w_offset = w_k_bytes;
        case (r_mode)
            2'b00:   w_offset = w_k_bytes;
            2'b01:   w_offset = w_k_bytes + w_word;
            2'b10:   w_offset = w_k_bytes - w_n_bytes + w_word;
            default: w_offset = w_k_bytes - w_n_bytes;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (i_valid) w_state_nxt = (i_list != '0) ? ST_RUN : ST_DONE;
                ST_RUN:  if (i_ready && w_last) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // List datapath
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mask      <= '0;
            r_mode      <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_wb_offset <= '0;
        end else if (i_abort) begin
            r_mask <= '0;
            r_k    <= '0;
        end else if (w_accept) begin
            r_mask      <= i_list;
            r_mode      <= i_mode;
            r_n         <= w_list_cnt;
            r_k         <= '0;
            r_wb_offset <= w_wb_nxt;
        end else if (w_beat) begin
            r_mask <= w_mask_rest;
            r_k    <= r_k + (IDX_W + 1)'(1);
        end
    end

    // Outputs: beat fields are forced to zero outside RUN so that the
    // reset and idle values are all zero.
    always_comb begin
        o_ready  = (r_state == ST_IDLE);
        o_valid  = (r_state == ST_RUN);
        o_done   = (r_state == ST_DONE);
        o_first  = 1'b0;
        o_last   = 1'b0;
        o_idx    = '0;
        o_offset = '0;
        if (r_state == ST_RUN) begin
            o_first  = (r_k == '0);
            o_last   = w_last;
            o_idx    = w_low_idx;
            o_offset = w_offset;
        end
    end

    assign o_wb_offset = r_wb_offset;

`ifdef ZAP_REGLIST_PC_FLAG_EN
    assign o_pc_hit = (r_state == ST_RUN) & (w_low_idx == IDX_W'(LIST_W - 1));
`endif

endmodule

// File: tb/tb_zap_reglist_sequencer.sv
module tb_zap_reglist_sequencer;

    localparam int LIST_W = 16;
    localparam int IDX_W  = 4;
    localparam int OFF_W  = 12;
    localparam int WB     = 4;

    logic              clk;
    logic              rst_n;
    logic              i_valid;
    logic              o_ready;
    logic [LIST_W-1:0] i_list;
    logic [1:0]        i_mode;
    logic              i_abort;
    logic              o_valid;
    logic              i_ready;
    logic [IDX_W-1:0]  o_idx;
    logic [OFF_W-1:0]  o_offset;
    logic              o_first;
    logic              o_last;
    logic [OFF_W-1:0]  o_wb_offset;
    logic              o_done;
`ifdef ZAP_REGLIST_PC_FLAG_EN
    logic              o_pc_hit;
`endif

    int n_checks = 0;
    int n_errors = 0;

    zap_reglist_sequencer #(
        .LIST_W(LIST_W), .IDX_W(IDX_W), .OFF_W(OFF_W), .WORD_BYTES(WB)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_list      (i_list),
        .i_mode      (i_mode),
        .i_abort     (i_abort),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_idx       (o_idx),
        .o_offset    (o_offset),
        .o_first     (o_first),
        .o_last      (o_last),
        .o_wb_offset (o_wb_offset),
        .o_done      (o_done)
`ifdef ZAP_REGLIST_PC_FLAG_EN
        ,
        .o_pc_hit    (o_pc_hit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference view: the transfer block starts at a mode-dependent address
    // relative to base and walks upward one word per register.
    // stall: 0 always ready, 1 alternate ready/not-ready, 2 random stalls
    task automatic run_list(input logic [LIST_W-1:0] list, input logic [1:0] mode,
                            input int stall);
        int  exp_idx[$];
        int  exp_off[$];
        int  n, k, start, wb, cyc;
        bit  done_seen;
        bit  tog;
        n = 0;
        for (int r = 0; r < LIST_W; r++) if (list[r]) n++;
        case (mode)
            2'b00:   start = 0;
            2'b01:   start = WB;
            2'b10:   start = WB - WB * n;
            default: start = -WB * n;
        endcase
        wb = mode[1] ? -(WB * n) : WB * n;
        k = 0;
        for (int r = 0; r < LIST_W; r++) begin
            if (list[r]) begin
                exp_idx.push_back(r);
                exp_off.push_back(start + WB * k);
                k++;
            end
        end

        @(negedge clk);
        i_valid = 1'b1;
        i_list  = list;
        i_mode  = mode;
        i_ready = 1'b0;
        chk("ready_idle", int'(o_ready), 1);
        @(negedge clk);
        i_valid = 1'b0;
        i_list  = $urandom();
        chk("wb_offset", int'($signed(o_wb_offset)), wb);

        k = 0;
        cyc = 0;
        done_seen = 1'b0;
        tog = 1'b1;
        while (!done_seen && cyc < 200) begin
            if (o_done) begin
                done_seen = 1'b1;
                chk("beats_left", exp_idx.size(), 0);
                chk("done_valid", int'(o_valid), 0);
            end else if (exp_idx.size() == 0) begin
                chk("extra_beat", int'(o_valid), 0);
            end else begin
                chk("valid_run", int'(o_valid), 1);
                chk("idx", int'(o_idx), exp_idx[0]);
                chk("offset", int'($signed(o_offset)), exp_off[0]);
                chk("first", int'(o_first), int'(k == 0));
                chk("last", int'(o_last), int'(exp_idx.size() == 1));
`ifdef ZAP_REGLIST_PC_FLAG_EN
                chk("pc_hit", int'(o_pc_hit), int'(exp_idx[0] == LIST_W - 1));
`endif
                case (stall)
                    0:       i_ready = 1'b1;
                    1:       begin i_ready = tog; tog = ~tog; end
                    default: i_ready = ($urandom_range(99) >= 40);
                endcase
                if (i_ready) begin
                    void'(exp_idx.pop_front());
                    void'(exp_off.pop_front());
                    k++;
                end
            end
            if (!done_seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        i_ready = 1'b0;
        if (!done_seen) chk("done_timeout", int'(done_seen), 1);
        @(negedge clk);
        chk("done_pulse", int'(o_done), 0);
        chk("ready_back", int'(o_ready), 1);
        chk("wb_held", int'($signed(o_wb_offset)), wb);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, int'(o_ready), 1);
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_done"}, int'(o_done), 0);
        chk({tag, "_idx"}, int'(o_idx), 0);
        chk({tag, "_off"}, int'(o_offset), 0);
        chk({tag, "_first"}, int'(o_first), 0);
        chk({tag, "_last"}, int'(o_last), 0);
        chk({tag, "_wb"}, int'(o_wb_offset), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_list  = '0;
        i_mode  = 2'b00;
        i_abort = 1'b0;
        i_ready = 1'b0;
        #2;
        check_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_list(16'h00F0, 2'b00, 0);
        run_list(16'h8001, 2'b11, 0);
        run_list(16'hFFFF, 2'b01, 1);
        run_list(16'h0000, 2'b10, 0);
        run_list(16'hFFFF, 2'b11, 2);
        run_list(16'h0001, 2'b10, 2);

        // Abort after the second beat of an IA list
        @(negedge clk);
        i_valid = 1'b1; i_list = 16'h0F00; i_mode = 2'b00;
        @(negedge clk);
        i_valid = 1'b0; i_ready = 1'b1;
        chk("ab_idx0", int'(o_idx), 8);
        @(negedge clk);
        chk("ab_idx1", int'(o_idx), 9);
        @(negedge clk);
        chk("ab_idx2", int'(o_idx), 10);
        i_abort = 1'b1; i_ready = 1'b0;
        @(negedge clk);
        i_abort = 1'b0;
        chk("ab_valid", int'(o_valid), 0);
        chk("ab_ready", int'(o_ready), 1);
        chk("ab_done", int'(o_done), 0);
        @(negedge clk);
        chk("ab_done2", int'(o_done), 0);
        chk("ab_valid2", int'(o_valid), 0);
        run_list(16'h0F00, 2'b00, 0);

        // Abort overrides a simultaneous request
        @(negedge clk);
        i_valid = 1'b1; i_list = 16'h0003; i_mode = 2'b01; i_abort = 1'b1;
        @(negedge clk);
        i_valid = 1'b0; i_abort = 1'b0;
        chk("abacc_valid", int'(o_valid), 0);
        chk("abacc_done", int'(o_done), 0);
        chk("abacc_ready", int'(o_ready), 1);

        // Async reset on the third beat
        @(negedge clk);
        i_valid = 1'b1; i_list = 16'h00F0; i_mode = 2'b10;
        @(negedge clk);
        i_valid = 1'b0; i_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mr_idx2", int'(o_idx), 6);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mr");
        @(negedge clk);
        i_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_after_valid", int'(o_valid), 0);
        run_list(16'h00F0, 2'b10, 0);

        // Randomized lists
        for (int t = 0; t < 40; t++) begin
            logic [LIST_W-1:0] l;
            int sel;
            sel = $urandom_range(7);
            if (sel == 0) l = '0;
            else if (sel == 1) l = '1;
            else l = LIST_W'($urandom());
            run_list(l, 2'($urandom_range(3)), $urandom_range(2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
